// File: rtl/ritc_ps_pkg.sv
// Shared definitions for the RITC phase-scan controller: FSM states and
// select-range boundaries for the capture-bit multiplexer.
package ritc_ps_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    EMIT,
    SHIFT,
    PSWAIT,
    REWIND
  } state_t;

  localparam logic [5:0] SEL_CLK0 = 6'd0;
  localparam logic [5:0] SEL_CH0  = 6'd3;
  localparam logic [5:0] SEL_VCDL = 6'd39;

endpackage

// File: rtl/ritc_ps_bitsel.sv
// Registered 40:1 selector picking one synchronized capture bit for the
// phase-scan accumulator; out-of-range selects read as constant 0.
module ritc_ps_bitsel
  import ritc_ps_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  sel,
  input  logic [2:0]  clk_q,
  input  logic [35:0] ch_q,
  input  logic        vcdl_q,
  output logic        bit_q
);

  logic       bit_next;
  logic [5:0] ch_idx;

  assign ch_idx = sel - SEL_CH0;

  always_comb begin
    bit_next = 1'b0;
    if (sel < SEL_CH0) begin
      bit_next = clk_q[sel[1:0] - SEL_CLK0[1:0]];
    end else if (sel < SEL_VCDL) begin
      bit_next = ch_q[ch_idx];
    end else if (sel == SEL_VCDL) begin
      bit_next = vcdl_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_next;
    end
  end

endmodule

// File: rtl/ritc_phase_scan_controller.sv
// Phase-scan sequencer: steps the MMCM phase, counts ones of a selected
// capture bit per step, streams results, then rewinds to the start phase.
module ritc_phase_scan_controller
  // The SETTLE parameter shares its name with a state, so states are imported
  // individually and that one state is referenced through the package scope.
  import ritc_ps_pkg::state_t, ritc_ps_pkg::IDLE, ritc_ps_pkg::SAMPLE,
         ritc_ps_pkg::EMIT, ritc_ps_pkg::SHIFT, ritc_ps_pkg::PSWAIT,
         ritc_ps_pkg::REWIND;
#(
  parameter int NSAMP_LOG2 = 8,
  parameter int SETTLE     = 16,
  parameter int PS_TIMEOUT = 1023,
  parameter int STEP_W     = 10
) (
  input  logic                  user_clk_i,
  input  logic                  user_rst_n_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [STEP_W-1:0]     nsteps_i,
  input  logic [5:0]            sel_i,
  input  logic [2:0]            clk_q_i,
  input  logic [11:0]           ch0_q_i,
  input  logic [11:0]           ch1_q_i,
  input  logic [11:0]           ch2_q_i,
  input  logic                  vcdl_q_i,
  output logic                  ps_en_o,
  output logic                  ps_incdec_o,
  input  logic                  ps_done_i,
  output logic                  scan_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [STEP_W-1:0]     result_step_o,
  output logic [NSAMP_LOG2:0]   result_count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int SAMPLES = 1 << NSAMP_LOG2;
  localparam int CW      = NSAMP_LOG2 + 1;
  localparam int TW_PS   = $clog2(PS_TIMEOUT + 1);
  localparam int TW_ST   = $clog2(SETTLE + 1);
  localparam int TW_A    = (TW_PS > TW_ST) ? TW_PS : TW_ST;
  localparam int TW      = (TW_A > CW) ? TW_A : CW;

  state_t            state;
  state_t            ret_state;
  logic [STEP_W-1:0] nsteps;
  logic [5:0]        sel;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] shifts;
  logic [CW-1:0]     count;
  logic [TW-1:0]     timer;
  logic              abort_pending;
  logic              sample_bit;
  logic              enter_rewind;
  logic              last_step;

  ritc_ps_bitsel u_bitsel (
    .clk    (user_clk_i),
    .rst_n  (user_rst_n_i),
    .sel    (sel),
    .clk_q  (clk_q_i),
    .ch_q   ({ch2_q_i, ch1_q_i, ch0_q_i}),
    .vcdl_q (vcdl_q_i),
    .bit_q  (sample_bit)
  );

  assign last_step = (step == nsteps - STEP_W'(1));

  // Every path into the rewind sequence funnels through this one decision.
  always_comb begin
    enter_rewind = 1'b0;
    case (state)
      ritc_ps_pkg::SETTLE, SAMPLE: enter_rewind = abort_i;
      EMIT:   enter_rewind = abort_i || (result_ready_i && last_step);
      PSWAIT: enter_rewind = ps_done_i &&
                             (ret_state == REWIND || abort_pending || abort_i);
      default: enter_rewind = 1'b0;
    endcase
  end

  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      state          <= IDLE;
      ret_state      <= IDLE;
      nsteps         <= '0;
      sel            <= '0;
      step           <= '0;
      shifts         <= '0;
      count          <= '0;
      timer          <= '0;
      abort_pending  <= 1'b0;
      ps_en_o        <= 1'b0;
      ps_incdec_o    <= 1'b0;
      scan_o         <= 1'b0;
      result_valid_o <= 1'b0;
      result_step_o  <= '0;
      result_count_o <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      ps_en_o <= 1'b0;
      scan_o  <= 1'b0;
      done_o  <= 1'b0;

      if (enter_rewind) begin
        result_valid_o <= 1'b0;
        if (shifts != '0) begin
          state       <= REWIND;
          ps_en_o     <= 1'b1;
          ps_incdec_o <= 1'b0;
        end else begin
          state  <= IDLE;
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start_i && !done_o) begin
              nsteps        <= nsteps_i;
              sel           <= sel_i;
              err_o         <= 1'b0;
              step          <= '0;
              shifts        <= '0;
              timer         <= '0;
              abort_pending <= 1'b0;
              if (nsteps_i == '0) begin
                done_o <= 1'b1;
              end else begin
                state  <= ritc_ps_pkg::SETTLE;
                busy_o <= 1'b1;
              end
            end
          end

          ritc_ps_pkg::SETTLE: begin
            if (timer == TW'(SETTLE - 1)) begin
              state  <= SAMPLE;
              timer  <= '0;
              count  <= '0;
              scan_o <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end

          SAMPLE: begin
            count <= count + CW'(sample_bit);
            if (timer == TW'(SAMPLES - 1)) begin
              state          <= EMIT;
              result_valid_o <= 1'b1;
              result_step_o  <= step;
              result_count_o <= count + CW'(sample_bit);
            end else begin
              timer <= timer + TW'(1);
            end
          end

          EMIT: begin
            if (result_ready_i) begin
              result_valid_o <= 1'b0;
              step           <= step + STEP_W'(1);
              state          <= SHIFT;
              ps_en_o        <= 1'b1;
              ps_incdec_o    <= 1'b1;
            end
          end

          // Timer starts at 1 so the timeout is measured from the PSEN cycle.
          SHIFT: begin
            shifts    <= shifts + STEP_W'(1);
            state     <= PSWAIT;
            ret_state <= ritc_ps_pkg::SETTLE;
            timer     <= TW'(1);
            if (abort_i) abort_pending <= 1'b1;
          end

          PSWAIT: begin
            if (abort_i) abort_pending <= 1'b1;
            if (ps_done_i) begin
              state <= ritc_ps_pkg::SETTLE;
              timer <= '0;
            end else if (timer == TW'(PS_TIMEOUT - 1)) begin
              state  <= IDLE;
              err_o  <= 1'b1;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              timer <= timer + TW'(1);
            end
          end

          REWIND: begin
            shifts    <= shifts - STEP_W'(1);
            state     <= PSWAIT;
            ret_state <= REWIND;
            timer     <= TW'(1);
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ritc_phase_scan_controller.sv
// Directed bench for ritc_phase_scan_controller with a simple MMCM PSDONE model.
module tb_ritc_phase_scan_controller;

  localparam int NSAMP_LOG2 = 8;
  localparam int SETTLE_CYC = 16;
  localparam int PS_TIMEOUT = 1023;
  localparam int STEP_W     = 10;
  localparam int PSDONE_LAT = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [STEP_W-1:0] nsteps_i = '0;
  logic [5:0]        sel_i = '0;
  logic [2:0]        clk_q_i = '0;
  logic [11:0]       ch0_q_i = '0;
  logic [11:0]       ch1_q_i = '0;
  logic [11:0]       ch2_q_i = '0;
  logic              vcdl_q_i = 1'b0;
  logic              ps_en_o;
  logic              ps_incdec_o;
  logic              ps_done_i = 1'b0;
  logic              scan_o;
  logic              result_valid_o;
  logic              result_ready_i = 1'b1;
  logic [STEP_W-1:0] result_step_o;
  logic [NSAMP_LOG2:0] result_count_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  int n_checks = 0;
  int n_errors = 0;

  // bench-side bookkeeping, owned by the negedge monitor/model
  logic  clr = 1'b0;
  logic  model_on = 1'b1;
  int    cyc = 0;
  int    inc_cnt, dec_cnt, done_cnt, scan_cnt, n_res, order_bad, overlap;
  int    first_en_cyc, done_cyc, lat_cnt;
  logic  outstanding;
  int    res_step [8];
  int    res_count [8];

  always #5 clk = ~clk;

  ritc_phase_scan_controller #(
    .NSAMP_LOG2 (NSAMP_LOG2),
    .SETTLE     (SETTLE_CYC),
    .PS_TIMEOUT (PS_TIMEOUT),
    .STEP_W     (STEP_W)
  ) dut (
    .user_clk_i     (clk),
    .user_rst_n_i   (rst_n),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .nsteps_i       (nsteps_i),
    .sel_i          (sel_i),
    .clk_q_i        (clk_q_i),
    .ch0_q_i        (ch0_q_i),
    .ch1_q_i        (ch1_q_i),
    .ch2_q_i        (ch2_q_i),
    .vcdl_q_i       (vcdl_q_i),
    .ps_en_o        (ps_en_o),
    .ps_incdec_o    (ps_incdec_o),
    .ps_done_i      (ps_done_i),
    .scan_o         (scan_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_step_o  (result_step_o),
    .result_count_o (result_count_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clr) begin
      inc_cnt <= 0; dec_cnt <= 0; done_cnt <= 0; scan_cnt <= 0; n_res <= 0;
      order_bad <= 0; first_en_cyc <= -1; done_cyc <= -1;
      lat_cnt <= 0; outstanding <= 1'b0; ps_done_i <= 1'b0;
    end else begin
      ps_done_i <= 1'b0;
      if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) begin
          ps_done_i   <= 1'b1;
          outstanding <= 1'b0;
        end
      end
      if (ps_en_o) begin
        if (outstanding) overlap <= overlap + 1;
        outstanding <= 1'b1;
        if (model_on) lat_cnt <= PSDONE_LAT;
        if (inc_cnt == 0 && dec_cnt == 0) first_en_cyc <= cyc;
        if (ps_incdec_o) begin
          inc_cnt <= inc_cnt + 1;
          if (dec_cnt != 0) order_bad <= order_bad + 1;
        end else begin
          dec_cnt <= dec_cnt + 1;
        end
      end
      if (done_o) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (scan_o) scan_cnt <= scan_cnt + 1;
      if (result_valid_o && result_ready_i) begin
        if (n_res < 8) begin
          res_step[n_res]  <= int'(result_step_o);
          res_count[n_res] <= int'(result_count_o);
        end
        n_res <= n_res + 1;
        $display("result accepted: step=%0d count=%0d", result_step_o, result_count_o);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic start_scan(input logic [STEP_W-1:0] n, input logic [5:0] s);
    nsteps_i = n;
    sel_i    = s;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    tick();
    tick();
    check(tag, done_cnt, 1);
  endtask

  initial begin
    overlap = 0;
    clear_stats();
    tick();
    // Reset state
    check("rst_outputs", {ps_en_o, ps_incdec_o, scan_o, result_valid_o, result_step_o,
                          result_count_o, busy_o, done_o, err_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: three steps on VCDL held high
    vcdl_q_i = 1'b1;
    result_ready_i = 1'b1;
    clear_stats();
    start_scan(10'd3, 6'd39);
    check("s1_busy", busy_o, 1);
    wait_done(5000, "s1_done_once");
    check("s1_nres", n_res, 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("s1_step%0d", k), res_step[k], k);
      check($sformatf("s1_count%0d", k), res_count[k], 256);
    end
    check("s1_incs", inc_cnt, 2);
    check("s1_decs", dec_cnt, 2);
    check("s1_order", order_bad, 0);
    check("s1_err", err_o, 0);
    check("s1_busy_end", busy_o, 0);

    // 2: single step on toggling ch0[1]
    vcdl_q_i = 1'b0;
    clear_stats();
    start_scan(10'd1, 6'd4);
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      ch0_q_i[1] = ~ch0_q_i[1];
      tick();
    end
    tick();
    check("s2_done", done_cnt, 1);
    check("s2_nres", n_res, 1);
    check("s2_step", res_step[0], 0);
    check("s2_count", res_count[0], 128);
    check("s2_no_psen", inc_cnt + dec_cnt, 0);

    // 3: abort during step-2 sampling
    vcdl_q_i = 1'b1;
    clear_stats();
    start_scan(10'd4, 6'd39);
    for (int i = 0; i < 3000 && scan_cnt < 3; i++) tick();
    check("s3_reach_step2", scan_cnt, 3);
    repeat (20) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("s3_valid_low", result_valid_o, 0);
    wait_done(500, "s3_done");
    check("s3_nres", n_res, 2);
    check("s3_step1", res_step[1], 1);
    check("s3_incs", inc_cnt, 2);
    check("s3_decs", dec_cnt, 2);
    check("s3_err", err_o, 0);

    // 4: PSDONE never returns
    model_on = 1'b0;
    clear_stats();
    start_scan(10'd3, 6'd39);
    wait_done(3000, "s4_done");
    check("s4_err", err_o, 1);
    check("s4_timeout_cycles", done_cyc - first_en_cyc, PS_TIMEOUT);
    check("s4_incs", inc_cnt, 1);
    check("s4_no_rewind", dec_cnt, 0);
    model_on = 1'b1;

    // 5: backpressure at step 0, out-of-range select reads 0
    clk_q_i = 3'b111; ch0_q_i = '1; ch1_q_i = '1; ch2_q_i = '1; vcdl_q_i = 1'b1;
    result_ready_i = 1'b0;
    clear_stats();
    start_scan(10'd2, 6'd45);
    check("s5_err_cleared", err_o, 0);
    for (int i = 0; i < 1000 && !result_valid_o; i++) tick();
    check("s5_valid", result_valid_o, 1);
    begin
      logic [STEP_W-1:0]   held_step;
      logic [NSAMP_LOG2:0] held_count;
      int bad;
      held_step  = result_step_o;
      held_count = result_count_o;
      bad = 0;
      repeat (50) begin
        tick();
        if (!result_valid_o || result_step_o != held_step || result_count_o != held_count) bad++;
      end
      check("s5_hold_stable", bad, 0);
      check("s5_hold_step", held_step, 0);
      check("s5_hold_count", held_count, 0);
      check("s5_no_psen_hold", inc_cnt, 0);
    end
    result_ready_i = 1'b1;
    wait_done(2000, "s5_done");
    check("s5_nres", n_res, 2);
    check("s5_incs", inc_cnt, 1);
    check("s5_decs", dec_cnt, 1);

    // 6: zero-step scan, then reset in the middle of sampling
    clear_stats();
    start_scan(10'd0, 6'd39);
    check("s6_zero_done", done_o, 1);
    check("s6_zero_busy", busy_o, 0);
    tick();
    check("s6_zero_pulse", done_o, 0);
    start_scan(10'd2, 6'd39);
    for (int i = 0; i < 500 && scan_cnt == 0; i++) tick();
    repeat (10) tick();
    check("s6_busy_before_rst", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("s6_rst_outputs", {ps_en_o, ps_incdec_o, scan_o, result_valid_o, result_step_o,
                             result_count_o, busy_o, done_o, err_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    check("no_psen_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ritc_phase_scan_controller.md
# ritc_phase_scan_controller

Sequencer for the RITC phase-scan datapath. Steps the CLK_PS MMCM phase one increment at a time and pulses the scan request at each step. It counts how often one selected synchronized capture bit (CLK, CH0–CH2 data, or VCDL) reads high over a fixed sample window, then streams one result per step. When the scan ends or is aborted, it rewinds the MMCM to the starting phase. It lives in the user_clk_i domain between the register interface and the phase-scanner capture registers.

## Interface
Parameters:
- NSAMP_LOG2, 8, log2 of samples per step; window = 2^NSAMP_LOG2 cycles
- SETTLE, 16, idle cycles between phase-shift completion and sampling
- PS_TIMEOUT, 1023, maximum cycles to wait for ps_done_i
- STEP_W, 10, width of step counters

Ports:
- user_clk_i  in  1  sole clock; also drives MMCM PSCLK
- user_rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse that starts a scan; ignored while busy_o
- abort_i  in  1  one-cycle pulse that terminates the scan early, with rewind
- nsteps_i  in  STEP_W  number of measured steps; latched on start_i
- sel_i  in  6  bit select, latched on start_i: 0–2 = clk_q_i[sel]; 3–38 = channel bit (sel-3) over {ch2,ch1,ch0}; 39 = vcdl_q_i; 40–63 = constant 0
- clk_q_i  in  3  synchronized CLK captures
- ch0_q_i, ch1_q_i, ch2_q_i  in  12 each  synchronized data captures
- vcdl_q_i  in  1  synchronized VCDL capture
- ps_en_o  out  1  MMCM PSEN, one-cycle pulse
- ps_incdec_o  out  1  MMCM PSINCDEC: 1 = increment, 0 = decrement
- ps_done_i  in  1  MMCM PSDONE
- scan_o  out  1  scan request pulse to the scanner
- result_valid_o  out  1  result available
- result_ready_i  in  1  consumer accepts the result
- result_step_o  out  STEP_W  step index of the result
- result_count_o  out  NSAMP_LOG2+1  number of ones in the window
- busy_o  out  1  high from the cycle after start_i until done_o
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky PSDONE-timeout flag; cleared on start_i

## Operation
- Reset value of every output is 0. Internal state on reset: state = IDLE, counters = 0.
- IDLE: on start_i, latch nsteps_i and sel_i, clear err_o, step = 0, shifts = 0.
  - If nsteps = 0, pulse done_o on the next cycle and remain in IDLE.
  - Otherwise go to SETTLE.
- SETTLE: count SETTLE cycles, then go to SAMPLE.
- SAMPLE:
  - scan_o pulses on the first SAMPLE cycle.
  - For 2^NSAMP_LOG2 cycles, add the selected bit to count.
  - count range is 0 to 2^NSAMP_LOG2 inclusive, so it is one bit wider than NSAMP_LOG2.
- EMIT:
  - Hold result_valid_o with {step, count} stable until result_ready_i is seen high at a clock edge.
  - After acceptance: if step = nsteps-1, go to REWIND; otherwise step++ and go to SHIFT.
- SHIFT: ps_en_o = 1 and ps_incdec_o = 1 for one cycle, shifts++, then go to PSWAIT.
- PSWAIT: on ps_done_i, return to the state that issued the shift.
  - A SHIFT-issued shift returns to SETTLE.
  - A REWIND-issued shift returns to REWIND.
  - If PS_TIMEOUT cycles elapse first, set err_o, pulse done_o, go to IDLE, and do not rewind.
- REWIND:
  - While shifts ≠ 0: ps_en_o = 1 with ps_incdec_o = 0, shifts--, go to PSWAIT.
  - When shifts = 0: pulse done_o and go to IDLE.
- Abort:
  - From SETTLE, SAMPLE or EMIT, go to REWIND immediately; result_valid_o drops and any pending result is discarded.
  - From PSWAIT, wait for ps_done_i or timeout, then go to REWIND.
  - In REWIND or IDLE, abort is ignored.
- Never issue ps_en_o while a shift is outstanding.
- start_i arriving together with done_o is ignored.

## Timing
- Step 0 is measured at the initial phase. Step k is measured after k increments.
- A full scan makes nsteps-1 increments and nsteps-1 decrements.
- Per step, with no backpressure: 1 (SHIFT) + PSDONE latency + SETTLE + 2^NSAMP_LOG2 + 1 (EMIT) cycles.
- The selected bit is registered before the accumulator: a sample taken on SAMPLE cycle n reflects the input at cycle n-1. This is one pipeline stage, accounted for inside SETTLE.
- result_valid_o asserts in the cycle after the last sample.
- done_o fires in the cycle after the final PSDONE of the rewind.

## Structure
- Shared package ritc_ps_pkg:
  - state enum: IDLE, SETTLE, SAMPLE, EMIT, SHIFT, PSWAIT, REWIND
  - select-range constants: SEL_CLK0 = 0, SEL_CH0 = 3, SEL_VCDL = 39
- Sub-module ritc_ps_bitsel: registered 40:1 mux from sel to a single bit.

## Test plan
- nsteps = 3, sel = 39, VCDL tied high, ready held high, MMCM model with PSDONE at 12 cycles. Expect:
  - results (0,256), (1,256), (2,256);
  - two increments then two decrements;
  - done_o once, err_o = 0.
- nsteps = 1, sel = 4 (ch0[1]) toggling every cycle. Expect one result with count = 128, no ps_en_o, done_o.
- nsteps = 4, abort_i during step-2 SAMPLE. Expect:
  - results for steps 0 and 1 only;
  - 2 decrements, then done_o.
- Model never asserts PSDONE. Expect err_o = 1 and done_o PS_TIMEOUT cycles after the first ps_en_o, with no rewind.
- result_ready_i low for 50 cycles at step 0. Expect result_valid_o and its data held stable, and no ps_en_o until acceptance.
- nsteps = 0 start, then reset asserted mid-SAMPLE of a new scan. Expect:
  - done_o one cycle after the first start;
  - all outputs 0 immediately on reset.
